wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the 32x32 register file; sole driver of the register file's RegW/DR/Reg_In write port.
- Merges two result sources:
  - single-cycle ALU results, which have priority;
  - load results from the data-memory interface, buffered in a small FIFO with a valid/ready handshake.
- Outputs are registered; an anti-starvation counter guarantees buffered loads retire.

---
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges priority ALU results with FIFO-buffered load results onto the regfile write port.
// Optional sub-word load formatting (LB/LH/LBU/LHU) enabled by defining RV_SUBWORD_EN.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ALU_V,
  input  logic [4:0]  ALU_RD,
  input  logic [31:0] ALU_DATA,
  input  logic        LD_V,
  output logic        LD_RDY,
  input  logic [4:0]  LD_RD,
  input  logic [31:0] LD_DATA,
  input  logic [2:0]  LD_F3,
  input  logic [1:0]  LD_OFF,
  output logic        WB_STALL,
  output logic        ALU_DROP,
  output logic        RegW,
  output logic [4:0]  DR,
  output logic [31:0] Reg_In
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [GW-1:0] AMAX = GW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_ent_t;

  ld_ent_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [GW-1:0]   age, age_nxt;
  logic [31:0]     ld_fmt;
  logic            fifo_ne, accept, push, pop;
  logic            alu_req, stall_pop, sel_alu;

`ifdef RV_SUBWORD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = LD_DATA[7:0];
    case (LD_OFF)
      2'd1:    ld_byte = LD_DATA[15:8];
      2'd2:    ld_byte = LD_DATA[23:16];
      2'd3:    ld_byte = LD_DATA[31:24];
      default: ld_byte = LD_DATA[7:0];
    endcase
    ld_half = LD_OFF[1] ? LD_DATA[31:16] : LD_DATA[15:0];
    case (LD_F3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = LD_DATA;
    endcase
  end
`else
  logic unused_fmt;
  assign unused_fmt = ^{LD_F3, LD_OFF};
  assign ld_fmt     = LD_DATA;
`endif

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign LD_RDY    = RST_N && (count != FULL);
  assign fifo_ne   = (count != '0);
  assign accept    = LD_V && LD_RDY;
  assign push      = accept && (LD_RD != 5'd0);

  assign alu_req   = ALU_V && (ALU_RD != 5'd0);
  assign stall_pop = WB_STALL && fifo_ne;
  assign sel_alu   = alu_req && !stall_pop;
  assign pop       = fifo_ne && !sel_alu;

  always_comb begin
    age_nxt = age;
    if (!fifo_ne || pop)  age_nxt = '0;
    else if (age != AMAX) age_nxt = age + GW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{rd: LD_RD, data: ld_fmt};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      age      <= '0;
      WB_STALL <= 1'b0;
      ALU_DROP <= 1'b0;
      RegW     <= 1'b0;
      DR       <= '0;
      Reg_In   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      age <= age_nxt;
      if (pop)                   WB_STALL <= 1'b0;
      else if (age_nxt == AMAX)  WB_STALL <= 1'b1;

      if (alu_req && stall_pop) ALU_DROP <= 1'b1;

      RegW <= sel_alu || pop;
      if (sel_alu) begin
        DR     <= ALU_RD;
        Reg_In <= ALU_DATA;
      end else if (pop) begin
        DR     <= mem[rd_ptr].rd;
        Reg_In <= mem[rd_ptr].data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU/load latency, starvation stall, drop flag, formatting, async reset.
module tb_wb_arbiter;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ALU_V;
  logic [4:0]  ALU_RD;
  logic [31:0] ALU_DATA;
  logic        LD_V;
  logic        LD_RDY;
  logic [4:0]  LD_RD;
  logic [31:0] LD_DATA;
  logic [2:0]  LD_F3;
  logic [1:0]  LD_OFF;
  logic        WB_STALL, ALU_DROP, RegW;
  logic [4:0]  DR;
  logic [31:0] Reg_In;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_V(ALU_V), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
    .LD_V(LD_V), .LD_RDY(LD_RDY), .LD_RD(LD_RD), .LD_DATA(LD_DATA),
    .LD_F3(LD_F3), .LD_OFF(LD_OFF),
    .WB_STALL(WB_STALL), .ALU_DROP(ALU_DROP),
    .RegW(RegW), .DR(DR), .Reg_In(Reg_In)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input string tag, input logic w, input logic [4:0] d, input logic [31:0] v);
    chk({tag, ".RegW"}, 32'(RegW), 32'(w));
    if (w) begin
      chk({tag, ".DR"}, 32'(DR), 32'(d));
      chk({tag, ".Reg_In"}, Reg_In, v);
    end
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ALU_V = v; ALU_RD = rd; ALU_DATA = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d,
                    input logic [2:0] f3, input logic [1:0] off);
    LD_V = v; LD_RD = rd; LD_DATA = d; LD_F3 = f3; LD_OFF = off;
  endtask

  initial begin
    RST_N = 1'b0;
    alu(0, 0, 0);
    ld(0, 0, 0, 3'b010, 0);
    #2;
    chk("rst.RegW", 32'(RegW), 0);
    chk("rst.DR", 32'(DR), 0);
    chk("rst.Reg_In", Reg_In, 0);
    chk("rst.WB_STALL", 32'(WB_STALL), 0);
    chk("rst.ALU_DROP", 32'(ALU_DROP), 0);
    chk("rst.LD_RDY", 32'(LD_RDY), 0);
    tick();
    RST_N = 1'b1;
    #1;
    chk("rel.LD_RDY", 32'(LD_RDY), 1);

    // ALU single-cycle latency, then hold on idle
    alu(1, 5, 32'hDEADBEEF);
    tick();
    wr("alu", 1, 5, 32'hDEADBEEF);
    alu(0, 0, 0);
    tick();
    wr("alu_idle", 0, 0, 0);
    chk("alu_idle.DR_hold", 32'(DR), 5);
    chk("alu_idle.Reg_In_hold", Reg_In, 32'hDEADBEEF);

    // back-to-back loads: second push coincides with first pop
    ld(1, 7, 32'h12345678, 3'b010, 0);
    tick();
    wr("ld1_push", 0, 0, 0);
    chk("ld1_push.LD_RDY", 32'(LD_RDY), 1);
    ld(1, 8, 32'hCAFEF00D, 3'b010, 0);
    tick();
    wr("ld1_pop", 1, 7, 32'h12345678);
    chk("ld1_pop.LD_RDY", 32'(LD_RDY), 1);
    ld(0, 0, 0, 3'b010, 0);
    tick();
    wr("ld2_pop", 1, 8, 32'hCAFEF00D);
    tick();
    wr("ld_idle", 0, 0, 0);

    // starvation: ALU wins every cycle while two loads queue up
    alu(1, 1, 32'h11);
    ld(1, 10, 32'hAAAA0001, 3'b010, 0);
    tick();
    wr("st_e1", 1, 1, 32'h11);
    chk("st_e1.LD_RDY", 32'(LD_RDY), 1);
    alu(1, 2, 32'h22);
    ld(1, 11, 32'hBBBB0002, 3'b010, 0);
    tick();
    wr("st_e2", 1, 2, 32'h22);
    chk("st_e2.LD_RDY", 32'(LD_RDY), 0);
    chk("st_e2.WB_STALL", 32'(WB_STALL), 0);
    ld(0, 0, 0, 3'b010, 0);
    alu(1, 4, 32'h44);
    tick();
    tick();
    wr("st_e4", 1, 4, 32'h44);
    chk("st_e4.WB_STALL", 32'(WB_STALL), 0);
    alu(1, 6, 32'h66);
    tick();
    wr("st_e5", 1, 6, 32'h66);
    chk("st_e5.WB_STALL", 32'(WB_STALL), 1);
    alu(0, 0, 0);
    tick();
    wr("st_pop1", 1, 10, 32'hAAAA0001);
    chk("st_pop1.WB_STALL", 32'(WB_STALL), 0);
    chk("st_pop1.LD_RDY", 32'(LD_RDY), 1);
    tick();
    wr("st_pop2", 1, 11, 32'hBBBB0002);
    tick();
    wr("st_idle", 0, 0, 0);
    chk("st_idle.ALU_DROP", 32'(ALU_DROP), 0);

    // protocol violation: ALU presented while stalled
    alu(1, 2, 32'h22);
    ld(1, 12, 32'hC0C0C0C0, 3'b010, 0);
    tick();
    ld(0, 0, 0, 3'b010, 0);
    tick(); tick(); tick(); tick();
    chk("drop_pre.WB_STALL", 32'(WB_STALL), 1);
    alu(1, 3, 32'h33);
    tick();
    wr("drop", 1, 12, 32'hC0C0C0C0);
    chk("drop.ALU_DROP", 32'(ALU_DROP), 1);
    chk("drop.WB_STALL", 32'(WB_STALL), 0);
    alu(0, 0, 0);
    tick();
    wr("drop_idle", 0, 0, 0);
    chk("drop_idle.ALU_DROP", 32'(ALU_DROP), 1);

    // load to x0 and ALU to x0 are both no-ops
    alu(1, 0, 32'h99);
    ld(1, 0, 32'h55555555, 3'b010, 0);
    tick();
    wr("x0_e1", 0, 0, 0);
    alu(0, 0, 0);
    ld(0, 0, 0, 3'b010, 0);
    tick();
    wr("x0_e2", 0, 0, 0);

    // sub-word formatting
    ld(1, 9, 32'h80FF0000, 3'b000, 3);
    tick();
    ld(1, 13, 32'h80FF0000, 3'b100, 3);
    tick();
`ifdef RV_SUBWORD_EN
    wr("lb", 1, 9, 32'hFFFFFF80);
`else
    wr("lb", 1, 9, 32'h80FF0000);
`endif
    ld(0, 0, 0, 3'b010, 0);
    tick();
`ifdef RV_SUBWORD_EN
    wr("lbu", 1, 13, 32'h00000080);
`else
    wr("lbu", 1, 13, 32'h80FF0000);
`endif

    // async reset with two loads queued
    alu(1, 1, 32'h11);
    ld(1, 14, 32'hE0E0E0E0, 3'b010, 0);
    tick();
    ld(1, 15, 32'hF0F0F0F0, 3'b010, 0);
    tick();
    chk("rq.LD_RDY_full", 32'(LD_RDY), 0);
    alu(0, 0, 0);
    ld(0, 0, 0, 3'b010, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rq.LD_RDY", 32'(LD_RDY), 0);
    chk("rq.RegW", 32'(RegW), 0);
    chk("rq.ALU_DROP", 32'(ALU_DROP), 0);
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rq_after.RegW", 32'(RegW), 0);
      chk("rq_after.LD_RDY", 32'(LD_RDY), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
